// File: rtl/flopens_pipe.sv
// flopens_pipe: elastic pipeline of DEPTH enable flops with per-stage valid
// bits and ready/valid handshakes. Bubbles collapse: a stage loads whenever it
// is empty or its occupant moves on in the same cycle.
module flopens_pipe #(
    parameter int unsigned     WIDTH          = 8,
    parameter int unsigned     DEPTH          = 2,
    parameter logic [WIDTH-1:0] INIT          = '0,
    parameter bit              CLEAR_ON_FLUSH = 1'b0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] adv;
    logic [DEPTH-1:0] src_valid;
    logic [WIDTH-1:0] data     [DEPTH];
    logic [WIDTH-1:0] src_data [DEPTH];
    logic             in_fire;
    logic             out_fire;

    // Advance chain: a stage may load if it, or any stage closer to the output,
    // is empty, or the consumer is taking the last stage. Built as a running
    // OR from the output side so no vector feeds back into itself.
    always_comb begin
        logic        run;
        int unsigned idx;
        adv = '0;
        run = out_ready | ~valid[DEPTH-1];
        adv[DEPTH-1] = run;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            idx      = DEPTH - 1 - i;
            run      = run | ~valid[idx];
            adv[idx] = run;
        end
    end

    // Source of each stage: the producer for stage 0, the previous stage otherwise.
    always_comb begin
        src_valid    = '0;
        src_valid[0] = in_valid;
        src_data[0]  = in_data;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            src_valid[i] = valid[i-1];
            src_data[i]  = data[i-1];
        end
    end

    // Handshake outputs and transfer strobes.
    always_comb begin
        in_ready  = adv[0] & ~flush;
        out_valid = valid[DEPTH-1];
        out_data  = data[DEPTH-1];
        in_fire   = in_valid & in_ready;
        out_fire  = out_valid & out_ready;
    end

    // Stage registers and occupancy count: reset, then flush, then normal advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= '0;
            count <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data[i] <= INIT;
            end
        end else if (flush) begin
            valid <= '0;
            count <= '0;
            if (CLEAR_ON_FLUSH) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    data[i] <= INIT;
                end
            end
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (adv[i]) begin
                    valid[i] <= src_valid[i];
                    // Payload only loads with a valid source to save toggling.
                    if (src_valid[i]) begin
                        data[i] <= src_data[i];
                    end
                end
            end
            count <= count + CW'(in_fire) - CW'(out_fire);
        end
    end

endmodule

// File: tb/tb_flopens_pipe.sv
// tb_flopens_pipe: randomized and directed stimulus against a queue/position
// model of the elastic pipe, with two DUTs differing only in CLEAR_ON_FLUSH.
module tb_flopens_pipe;

    localparam int unsigned     W = 8;
    localparam int unsigned     D = 3;
    localparam logic [W-1:0]    IV = 8'hA5;

    logic         clk = 1'b0;
    logic         reset, flush, in_valid, out_ready;
    logic [W-1:0] in_data;

    logic         c_in_ready, c_out_valid;
    logic [W-1:0] c_out_data;
    logic [1:0]   c_count;
    logic         k_in_ready, k_out_valid;
    logic [W-1:0] k_out_data;
    logic [1:0]   k_count;

    int checks   = 0;
    int failures = 0;
    bit armed    = 1'b0;

    // Model: queue of held items, oldest first, each with its stage position.
    logic [W-1:0] mq[$];
    int           mp[$];

    flopens_pipe #(.WIDTH(W), .DEPTH(D), .INIT(IV), .CLEAR_ON_FLUSH(1'b1)) u_clr (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(c_in_ready), .in_data(in_data),
        .out_valid(c_out_valid), .out_ready(out_ready), .out_data(c_out_data),
        .count(c_count)
    );

    flopens_pipe #(.WIDTH(W), .DEPTH(D), .INIT(IV), .CLEAR_ON_FLUSH(1'b0)) u_keep (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(k_in_ready), .in_data(in_data),
        .out_valid(k_out_valid), .out_ready(out_ready), .out_data(k_out_data),
        .count(k_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit m_out_valid();
        return (mq.size() > 0) && (mp[0] == D - 1);
    endfunction

    function automatic bit m_in_ready();
        return !flush && ((mq.size() < D) || out_ready);
    endfunction

    // Model update on each rising edge from the inputs and the model's own outputs.
    always @(posedge clk) begin
        bit o_x, i_x;
        int ahead;
        o_x = m_out_valid() && out_ready;
        i_x = in_valid && m_in_ready();
        if (reset) begin
            armed = 1'b1;
            mq.delete();
            mp.delete();
        end else if (flush) begin
            mq.delete();
            mp.delete();
        end else begin
            if (o_x) begin
                void'(mq.pop_front());
                void'(mp.pop_front());
            end
            ahead = D;
            for (int k = 0; k < mp.size(); k++) begin
                if (mp[k] + 1 < ahead) mp[k] = mp[k] + 1;
                ahead = mp[k];
            end
            if (i_x) begin
                mq.push_back(in_data);
                mp.push_back(0);
            end
        end
    end

    // Every-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (armed) begin
            check("in_ready_clr",  c_in_ready,  m_in_ready());
            check("in_ready_keep", k_in_ready,  m_in_ready());
            check("out_valid_clr", c_out_valid, m_out_valid());
            check("out_valid_keep",k_out_valid, m_out_valid());
            check("count_clr",     c_count,     mq.size());
            check("count_keep",    k_count,     mq.size());
            if (m_out_valid()) begin
                check("out_data_clr",  c_out_data, mq[0]);
                check("out_data_keep", k_out_data, mq[0]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (D + 2) step();
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        step(); step();
        reset = 1'b0;
        #1;
        check("rst_out_valid", c_out_valid, 1'b0);
        check("rst_out_data",  c_out_data,  8'hA5);
        check("rst_count",     c_count,     2'd0);
        check("rst_in_ready",  c_in_ready,  1'b1);

        // Back-to-back stream with the consumer always ready.
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = W'(i + 1);
            step();
            if (i == 1) check("lat_not_yet", c_out_valid, 1'b0);
            if (i == 2) begin
                check("lat_first_valid", c_out_valid, 1'b1);
                check("lat_first_data",  c_out_data,  8'h01);
            end
            if (i >= 3) check("stream_count", c_count, 2'd3);
        end
        drain();

        // Backpressure: three accepted, fourth waits until the consumer frees a slot.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = W'(8'h10 + i);
            step();
        end
        in_data = 8'h13;
        #1;
        check("bp_count",    c_count,    2'd3);
        check("bp_in_ready", c_in_ready, 1'b0);
        check("bp_head",     c_out_data, 8'h10);
        step(); step();
        out_ready = 1'b1;
        #1;
        check("bp_ready_pass", c_in_ready, 1'b1);
        step();
        in_valid = 1'b0;
        #1;
        check("bp_swap_count", c_count,    2'd3);
        check("bp_swap_head",  c_out_data, 8'h11);
        drain();

        // Bubble collapse with the consumer stalled.
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h20; step();
        in_valid = 1'b0;                  step();
        in_valid = 1'b1; in_data = 8'h21; step();
        in_data = 8'h22;                  step();
        in_valid = 1'b0;
        #1;
        check("bub_count", c_count,     2'd3);
        check("bub_valid", c_out_valid, 1'b1);
        check("bub_head",  c_out_data,  8'h20);
        drain();

        // Flush on a full pipe: output consumed, input refused.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = W'(8'h30 + i);
            step();
        end
        flush = 1'b1; out_ready = 1'b1; in_data = 8'h33;
        #1;
        check("fl_in_ready",  c_in_ready,  1'b0);
        check("fl_out_valid", c_out_valid, 1'b1);
        check("fl_out_data",  c_out_data,  8'h30);
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("fl_count",     c_count,     2'd0);
        check("fl_out_valid2",c_out_valid, 1'b0);
        check("fl_clr_data",  c_out_data,  8'hA5);
        check("fl_keep_data", k_out_data,  8'h30);

        // Reset and flush together mid-stream: reset wins.
        out_ready = 1'b1;
        in_valid = 1'b1; in_data = 8'h40; step();
        in_data = 8'h41; step();
        in_data = 8'h42; step();
        reset = 1'b1; flush = 1'b1;
        step();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        check("rf_count",     k_count,    2'd0);
        check("rf_keep_data", k_out_data, 8'hA5);
        check("rf_clr_data",  c_out_data, 8'hA5);

        // Randomized traffic with occasional flush and reset.
        for (int n = 0; n < 2000; n++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            reset     = ($urandom_range(0, 149) == 0);
            step();
        end
        reset = 1'b0; flush = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
